// File: rtl/serial_rx_fifo.sv
// Oversampled serial receiver with 2-of-3 majority bit sampling, optional parity,
// and a small receive FIFO that carries per-frame error flags alongside the data.
module serial_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLK_RX,
   input  logic                 RST,
   input  logic                 RX,
   input  logic                 RD_ACK,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 RDY,
   output logic                 PAR_ERR,
   output logic                 FRM_ERR,
   output logic                 OVR
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int EW = DATA_BITS + 2;

   localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
   localparam logic          ODD    = (PARITY == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   logic rx_s1, rx_s2, rx_d;
   logic ack_s1, ack_s2, ack_d;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge CLK_RX) begin
      if (!RST) begin
         rx_s1  <= 1'b1;
         rx_s2  <= 1'b1;
         rx_d   <= 1'b1;
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
         ack_d  <= 1'b0;
      end else begin
         rx_s1  <= RX;
         rx_s2  <= rx_s1;
         rx_d   <= rx_s2;
         ack_s1 <= RD_ACK;
         ack_s2 <= ack_s1;
         ack_d  <= ack_s2;
      end
   end

   logic rx_fall, ack_rise;
   assign rx_fall  = rx_d & ~rx_s2;
   assign ack_rise = ack_s2 & ~ack_d;

   state_t                 state;
   logic [TW-1:0]          tick;
   logic [BW-1:0]          bit_cnt;
   logic [DATA_BITS-1:0]   shreg;
   logic                   smp_a, smp_b, maj;
   logic                   par_r, frm_r, wr_req;

   // Third sample is the live synchronised line at tick T_S2.
   assign maj = (smp_a & smp_b) | (smp_a & rx_s2) | (smp_b & rx_s2);

   always_ff @(posedge CLK_RX) begin
      if (!RST) begin
         state   <= S_IDLE;
         tick    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         smp_a   <= 1'b1;
         smp_b   <= 1'b1;
         par_r   <= 1'b0;
         frm_r   <= 1'b0;
         wr_req  <= 1'b0;
      end else begin
         wr_req <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_fall) begin
                  state <= S_START;
                  tick  <= '0;
                  par_r <= 1'b0;
               end
            end
            default: begin
               tick <= tick + 1'b1;
               if (tick == T_S0) smp_a <= rx_s2;
               if (tick == T_S1) smp_b <= rx_s2;
               if (tick == T_S2) begin
                  case (state)
                     S_START: if (maj) state <= S_IDLE;
                     S_DATA:  shreg <= {maj, shreg[DATA_BITS-1:1]};
                     S_PAR:   par_r <= ^shreg ^ maj ^ ODD;
                     S_STOP: begin
                        frm_r  <= ~maj;
                        wr_req <= 1'b1;
                        state  <= S_IDLE;
                     end
                     default: ;
                  endcase
               end
               if (tick == T_END) begin
                  tick <= '0;
                  case (state)
                     S_START: begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                     end
                     S_DATA: begin
                        if (bit_cnt == B_LAST) state <= (PARITY != 0) ? S_PAR : S_STOP;
                        else                   bit_cnt <= bit_cnt + 1'b1;
                     end
                     S_PAR:   state <= S_STOP;
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wp, rp, rp_next, count;
   logic [EW-1:0] wdata, head;
   logic          empty, full, pop, wr_ok;

   assign wdata   = {frm_r, par_r, shreg};
   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop     = ack_rise & ~empty;
   assign wr_ok   = wr_req & (~full | pop);
   assign rp_next = rp + 1'b1;
   assign count   = wp - rp;

   // NOTE: the storage array has no reset; only pointers and the head register need one.
   always_ff @(posedge CLK_RX) begin
      if (wr_ok) mem[wp[AW-1:0]] <= wdata;
   end

   // Head is registered so the outputs hold the last entry once the FIFO drains.
   always_ff @(posedge CLK_RX) begin
      if (!RST) begin
         wp   <= '0;
         rp   <= '0;
         head <= '0;
         OVR  <= 1'b0;
      end else begin
         if (wr_ok) wp <= wp + 1'b1;
         if (pop) begin
            rp  <= rp_next;
            OVR <= 1'b0;
         end else if (wr_req && full) begin
            OVR <= 1'b1;
         end
         if (wr_ok && empty) begin
            head <= wdata;
         end else if (pop) begin
            if (count > (AW+1)'(1)) head <= mem[rp_next[AW-1:0]];
            else if (wr_ok)         head <= wdata;
         end
      end
   end

   assign RDY = ~empty;
   assign {FRM_ERR, PAR_ERR, DATA} = head;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Randomised bench for serial_rx_fifo: a no-parity instance and an even-parity instance,
// both compared against a queue-based model of frames, FIFO contents and the overrun flag.
module tb_serial_rx_fifo;

   localparam int OS    = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rx0, rx1, ack0, ack1;
   logic [7:0] data0, data1;
   logic       rdy0, perr0, ferr0, ovr0;
   logic       rdy1, perr1, ferr1, ovr1;

   serial_rx_fifo u_dut0 (
      .CLK_RX(clk), .RST(rst), .RX(rx0), .RD_ACK(ack0),
      .DATA(data0), .RDY(rdy0), .PAR_ERR(perr0), .FRM_ERR(ferr0), .OVR(ovr0)
   );

   serial_rx_fifo #(.PARITY(1)) u_dut1 (
      .CLK_RX(clk), .RST(rst), .RX(rx1), .RD_ACK(ack1),
      .DATA(data1), .RDY(rdy1), .PAR_ERR(perr1), .FRM_ERR(ferr1), .OVR(ovr1)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Model entry layout: {framing error, parity error, data byte}
   typedef logic [9:0] entry_t;
   entry_t q0[$];
   entry_t q1[$];
   entry_t last0 = '0, last1 = '0;
   bit     movr0 = 1'b0, movr1 = 1'b0;

   task automatic model_write(input int w, input entry_t e);
      if (w == 0) begin
         if (q0.size() < DEPTH) q0.push_back(e); else movr0 = 1'b1;
         if (q0.size() > 0) last0 = q0[0];
      end else begin
         if (q1.size() < DEPTH) q1.push_back(e); else movr1 = 1'b1;
         if (q1.size() > 0) last1 = q1[0];
      end
   endtask

   task automatic model_pop(input int w);
      if (w == 0) begin
         if (q0.size() > 0) begin void'(q0.pop_front()); movr0 = 1'b0; end
         if (q0.size() > 0) last0 = q0[0];
      end else begin
         if (q1.size() > 0) begin void'(q1.pop_front()); movr1 = 1'b0; end
         if (q1.size() > 0) last1 = q1[0];
      end
   endtask

   task automatic model_clear();
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
      movr0 = 1'b0; movr1 = 1'b0;
   endtask

   task automatic compare(input int w, input string tag);
      if (w == 0) begin
         check({tag, ".rdy0"},  32'(rdy0),  32'(q0.size() > 0));
         check({tag, ".data0"}, 32'(data0), 32'(last0[7:0]));
         check({tag, ".perr0"}, 32'(perr0), 32'(last0[8]));
         check({tag, ".ferr0"}, 32'(ferr0), 32'(last0[9]));
         check({tag, ".ovr0"},  32'(ovr0),  32'(movr0));
      end else begin
         check({tag, ".rdy1"},  32'(rdy1),  32'(q1.size() > 0));
         check({tag, ".data1"}, 32'(data1), 32'(last1[7:0]));
         check({tag, ".perr1"}, 32'(perr1), 32'(last1[8]));
         check({tag, ".ferr1"}, 32'(ferr1), 32'(last1[9]));
         check({tag, ".ovr1"},  32'(ovr1),  32'(movr1));
      end
   endtask

   task automatic set_rx(input int w, input logic v);
      if (w == 0) rx0 = v; else rx1 = v;
   endtask

   task automatic hold_bit(input int w, input logic v);
      set_rx(w, v);
      repeat (OS) @(negedge clk);
   endtask

   // Instance 1 carries an even-parity bit; instance 0 has none.
   task automatic send_frame(input int w, input logic [7:0] d, input bit pbit, input bit stop_bit);
      logic [7:0] dv;
      dv = d;
      @(negedge clk);
      hold_bit(w, 1'b0);
      for (int i = 0; i < 8; i++) hold_bit(w, dv[i]);
      if (w == 1) hold_bit(w, pbit);
      hold_bit(w, stop_bit);
      set_rx(w, 1'b1);
      repeat ($urandom_range(4, 20)) @(negedge clk);
      model_write(w, {~stop_bit, (w == 1) ? (^dv ^ pbit) : 1'b0, dv});
   endtask

   task automatic do_pop(input int w, input int hold);
      @(negedge clk);
      if (w == 0) ack0 = 1'b1; else ack1 = 1'b1;
      repeat (hold) @(negedge clk);
      if (w == 0) ack0 = 1'b0; else ack1 = 1'b0;
      repeat (4) @(negedge clk);
      model_pop(w);
   endtask

   task automatic false_start(input int w);
      @(negedge clk);
      set_rx(w, 1'b0);
      repeat (4) @(negedge clk);
      set_rx(w, 1'b1);
      repeat (40) @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
      repeat (3) @(negedge clk);
      model_clear();
      compare(0, tag);
      compare(1, tag);
      rst = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
      repeat (4) @(negedge clk);
      compare(0, "reset");
      compare(1, "reset");
      rst = 1'b1;
      repeat (3) @(negedge clk);

      send_frame(0, 8'hA5, 1'b0, 1'b1);  compare(0, "a5");
      do_pop(0, 4);                      compare(0, "a5_pop");

      send_frame(1, 8'h03, 1'b1, 1'b1);  compare(1, "par_bad");
      do_pop(1, 4);
      send_frame(1, 8'h03, 1'b0, 1'b1);  compare(1, "par_good");
      do_pop(1, 4);                      compare(1, "par_pop");

      send_frame(0, 8'h55, 1'b0, 1'b0);  compare(0, "frm_bad");
      send_frame(0, 8'h12, 1'b0, 1'b1);  compare(0, "frm_next");
      do_pop(0, 4);                      compare(0, "frm_pop1");
      do_pop(0, 4);                      compare(0, "frm_pop2");

      false_start(0);                    compare(0, "false_start");
      do_pop(0, 4);                      compare(0, "ack_empty");
      send_frame(0, 8'h66, 1'b0, 1'b1);  compare(0, "after_false");
      do_pop(0, 4);

      for (int i = 1; i <= 5; i++) begin
         send_frame(0, 8'(i), 1'b0, 1'b1);
         compare(0, "fill");
      end
      for (int i = 0; i < 4; i++) begin
         do_pop(0, (i == 1) ? 24 : 4);
         compare(0, "drain");
      end

      send_frame(0, 8'h99, 1'b0, 1'b1);
      @(negedge clk);
      hold_bit(0, 1'b0);
      hold_bit(0, 1'b0);
      hold_bit(0, 1'b1);
      do_reset("mid_reset");
      send_frame(0, 8'h3C, 1'b0, 1'b1);  compare(0, "post_reset");
      do_pop(0, 4);                      compare(0, "post_reset_pop");

      for (int n = 0; n < 40; n++) begin
         int r, w;
         r = $urandom_range(0, 9);
         w = $urandom_range(0, 1);
         if (r < 5)      send_frame(w, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
         else if (r < 9) do_pop(w, $urandom_range(4, 20));
         else            false_start(w);
         compare(w, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
